// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared constants and state encoding for the CPU state dump unit.
package cpu_dbg_pkg;
    localparam int DUMP_NREG  = 32;
    localparam int DUMP_NWORD = 32;
    localparam logic SRC_REG = 1'b0;
    localparam logic SRC_MEM = 1'b1;
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_e;
endpackage

// File: rtl/state_dump_unit.sv
// state_dump_unit: streams 32 register-file entries then 32 data-memory words
// onto a valid/ready port, triggered by a cycle count or by start_i.
module state_dump_unit
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned DUMP_CYCLE = 1200,
    parameter bit          AUTO_EN    = 1'b1,
    parameter int          CNT_W      = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [4:0]  rf_addr_o,
    input  logic [31:0] rf_data_i,
    output logic [31:0] dm_addr_o,
    input  logic [31:0] dm_data_i,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic [31:0] dump_data_o,
    output logic        dump_src_o,
    output logic [4:0]  dump_idx_o,
    output logic        dump_last_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [5:0]       LAST_IDX = 6'(DUMP_NREG + DUMP_NWORD - 1);
    // A zero or unreachable trigger cycle can never match, so it disables the auto path.
    localparam bit AUTO_OK = AUTO_EN && (DUMP_CYCLE != 0) && (64'(DUMP_CYCLE) <= 64'(CNT_MAX));
    localparam logic [CNT_W-1:0] TRIG = CNT_W'(DUMP_CYCLE - 1);

    dump_state_e      state_q, state_d;
    logic [5:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             fired_q, fired_d;
    logic [31:0]      data_q, data_d;
    logic             src_q, src_d;
    logic [4:0]       didx_q, didx_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             auto_hit, go, hs, restart, fetch;

    assign auto_hit = AUTO_OK && !fired_q && (cyc_q == TRIG);
    assign go       = (state_q == IDLE) && (start_i || auto_hit);
    assign restart  = (state_q == DONE) && start_i;
    assign hs       = (state_q == SEND) && valid_q && dump_ready_i;
    assign fetch    = (state_q == FETCH);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cyc_q   <= '0;
            fired_q <= 1'b0;
            data_q  <= '0;
            src_q   <= 1'b0;
            didx_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            fired_q <= fired_d;
            data_q  <= data_d;
            src_q   <= src_d;
            didx_q  <= didx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = go ? FETCH : IDLE;
            FETCH:   state_d = SEND;
            SEND:    state_d = hs ? ((idx_q == LAST_IDX) ? DONE : FETCH) : SEND;
            DONE:    state_d = start_i ? FETCH : DONE;
            default: state_d = IDLE;
        endcase
    end

    // idx only moves on entry to FETCH, so the read addresses are stable through FETCH and SEND.
    always_comb begin
        idx_d   = (go || restart) ? 6'd0 : (hs && idx_q != LAST_IDX) ? idx_q + 6'd1 : idx_q;
        cyc_d   = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_W'(1);
        fired_d = fired_q | ((state_q == IDLE) && auto_hit);
        data_d  = fetch ? (idx_q[5] ? dm_data_i : rf_data_i) : data_q;
        src_d   = fetch ? idx_q[5] : src_q;
        didx_d  = fetch ? idx_q[4:0] : didx_q;
        last_d  = fetch ? (idx_q == LAST_IDX) : last_q;
        valid_d = fetch ? 1'b1 : hs ? 1'b0 : valid_q;
        done_d  = (hs && idx_q == LAST_IDX) ? 1'b1 : restart ? 1'b0 : done_q;
    end

    assign rf_addr_o    = idx_q[4:0];
    assign dm_addr_o    = {25'b0, idx_q[4:0], 2'b00};
    assign dump_valid_o = valid_q;
    assign dump_data_o  = data_q;
    assign dump_src_o   = src_q;
    assign dump_idx_o   = didx_q;
    assign dump_last_o  = last_q;
    assign busy_o       = (state_q == FETCH) || (state_q == SEND);
    assign done_o       = done_q;
endmodule

// File: tb/tb_state_dump_unit.sv
// tb_state_dump_unit: scoreboard bench for the state dump unit across three
// parameterisations (auto, manual-only, narrow counter).
module tb_state_dump_unit;
    typedef struct {
        logic        src;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst[3], start[3], ready[3];
    logic [4:0]  rf_addr[3], didx[3];
    logic [31:0] dm_addr[3], rf_data[3], dm_data[3], data[3];
    logic        valid[3], src[3], last[3], busy[3], done[3];
    logic [31:0] rf[32], dm[32];

    beat_t sbq[$];
    int checks = 0, errors = 0;
    int edge_n = 0, first_v = -1, last_edge = -1, nb = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_mem
        assign rf_data[g] = rf[rf_addr[g]];
        assign dm_data[g] = dm[dm_addr[g][6:2]];
    end

    state_dump_unit #(.DUMP_CYCLE(20), .AUTO_EN(1'b1), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .rf_addr_o(rf_addr[0]), .rf_data_i(rf_data[0]),
        .dm_addr_o(dm_addr[0]), .dm_data_i(dm_data[0]), .dump_valid_o(valid[0]), .dump_ready_i(ready[0]),
        .dump_data_o(data[0]), .dump_src_o(src[0]), .dump_idx_o(didx[0]), .dump_last_o(last[0]),
        .busy_o(busy[0]), .done_o(done[0]));
    state_dump_unit #(.DUMP_CYCLE(20), .AUTO_EN(1'b0), .CNT_W(16)) u_m (
        .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .rf_addr_o(rf_addr[1]), .rf_data_i(rf_data[1]),
        .dm_addr_o(dm_addr[1]), .dm_data_i(dm_data[1]), .dump_valid_o(valid[1]), .dump_ready_i(ready[1]),
        .dump_data_o(data[1]), .dump_src_o(src[1]), .dump_idx_o(didx[1]), .dump_last_o(last[1]),
        .busy_o(busy[1]), .done_o(done[1]));
    state_dump_unit #(.DUMP_CYCLE(5), .AUTO_EN(1'b1), .CNT_W(4)) u_s (
        .clk_i(clk), .rst_i(rst[2]), .start_i(start[2]), .rf_addr_o(rf_addr[2]), .rf_data_i(rf_data[2]),
        .dm_addr_o(dm_addr[2]), .dm_data_i(dm_data[2]), .dump_valid_o(valid[2]), .dump_ready_i(ready[2]),
        .dump_data_o(data[2]), .dump_src_o(src[2]), .dump_idx_o(didx[2]), .dump_last_o(last[2]),
        .busy_o(busy[2]), .done_o(done[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_dump();
        for (int i = 0; i < 64; i++) begin
            beat_t b;
            b.src  = (i >= 32);
            b.idx  = 5'(i % 32);
            b.data = (i < 32) ? rf[i] : dm[i - 32];
            b.last = (i == 63);
            sbq.push_back(b);
        end
    endtask

    // Sampled at the falling edge: what is seen here is what the next rising edge acts on.
    task automatic mon(input int k);
        if (busy[k] && !valid[k]) begin
            chk("rf_addr", 64'(rf_addr[k]), 64'(nb[4:0]));
            chk("dm_addr", 64'(dm_addr[k]), {57'b0, nb[4:0], 2'b00});
        end
        if (valid[k] && ready[k]) begin
            if (sbq.size() == 0) chk("extra_beat", 64'(sbq.size()), 64'd1);
            else begin
                beat_t e = sbq.pop_front();
                chk("beat_data", 64'(data[k]), 64'(e.data));
                chk("beat_src", 64'(src[k]), 64'(e.src));
                chk("beat_idx", 64'(didx[k]), 64'(e.idx));
                chk("beat_last", 64'(last[k]), 64'(e.last));
                nb++;
                if (last[k]) last_edge = edge_n + 1;
            end
        end
    endtask

    task automatic step(input int k);
        @(negedge clk);
        mon(k);
        @(posedge clk);
        #1;
        edge_n++;
        if (valid[k] && first_v < 0) first_v = edge_n;
    endtask

    task automatic rel(input int k);
        rst[k] = 1'b0;
        edge_n = 0;
        first_v = -1;
        last_edge = -1;
        nb = 0;
    endtask

    task automatic run_until_done(input int k, input int budget);
        for (int n = 0; n < budget && !done[k]; n++) step(k);
        chk("done_reached", 64'(done[k]), 64'd1);
    endtask

    task automatic chk_zero(input int k);
        chk("rst_valid", 64'(valid[k]), 64'd0);
        chk("rst_data", 64'(data[k]), 64'd0);
        chk("rst_busy", 64'(busy[k]), 64'd0);
        chk("rst_done", 64'(done[k]), 64'd0);
        chk("rst_misc", {rf_addr[k], dm_addr[k], didx[k], src[k], last[k]}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i] = 32'(100 + i);
            dm[i] = 32'(1000 + i);
        end
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            start[k] = 1'b0;
            ready[k] = 1'b1;
        end
        repeat (3) step(0);
        chk_zero(0);

        // Auto dump timing with ready held high
        rel(0);
        push_dump();
        run_until_done(0, 400);
        chk("a_first_valid_edge", 64'(first_v), 64'd21);
        chk("a_last_hs_edge", 64'(last_edge), 64'd148);
        chk("a_done_edge", 64'(edge_n), 64'd148);
        chk("a_beats", 64'(nb), 64'd64);
        chk("a_sb_empty", 64'(sbq.size()), 64'd0);

        // Backpressure on register beat 7 while the CPU rewrites RF[7]
        rst[0] = 1'b1;
        step(0);
        rel(0);
        push_dump();
        for (int n = 0; n < 200 && !(valid[0] && didx[0] == 5'd7 && !src[0]); n++) step(0);
        chk("bp_reach_beat7", {valid[0], didx[0]}, {1'b1, 5'd7});
        ready[0] = 1'b0;
        rf[7] = 32'hDEAD_BEEF;
        repeat (5) begin
            step(0);
            chk("bp_hold_data", 64'(data[0]), 64'd107);
            chk("bp_hold_valid", 64'(valid[0]), 64'd1);
            chk("bp_hold_addr", 64'(rf_addr[0]), 64'd7);
        end
        ready[0] = 1'b1;
        rf[7] = 32'd107;
        run_until_done(0, 400);
        chk("bp_beats", 64'(nb), 64'd64);
        chk("bp_sb_empty", 64'(sbq.size()), 64'd0);

        // Asynchronous reset in the middle of beat 30
        rst[0] = 1'b1;
        step(0);
        rel(0);
        push_dump();
        for (int n = 0; n < 200 && !(valid[0] && didx[0] == 5'd30 && !src[0]); n++) step(0);
        chk("mr_reach_beat30", {valid[0], didx[0]}, {1'b1, 5'd30});
        #1 rst[0] = 1'b1;
        #1 chk_zero(0);
        sbq.delete();
        step(0);
        rel(0);
        push_dump();
        run_until_done(0, 400);
        chk("mr_first_valid_edge", 64'(first_v), 64'd21);
        chk("mr_done_edge", 64'(edge_n), 64'd148);
        chk("mr_beats", 64'(nb), 64'd64);

        // Manual-only instance
        rel(1);
        repeat (50) step(1);
        chk("m_idle_busy", 64'(busy[1]), 64'd0);
        chk("m_idle_done", 64'(done[1]), 64'd0);
        push_dump();
        start[1] = 1'b1;
        step(1);
        start[1] = 1'b0;
        chk("m_start_busy", 64'(busy[1]), 64'd1);
        for (int n = 0; n < 50 && !(valid[1] && nb >= 3); n++) step(1);
        start[1] = 1'b1;
        step(1);
        start[1] = 1'b0;
        run_until_done(1, 400);
        chk("m_beats", 64'(nb), 64'd64);
        chk("m_sb_empty", 64'(sbq.size()), 64'd0);
        repeat (3) step(1);
        chk("m_done_sticky", {done[1], valid[1], busy[1]}, 64'b100);
        nb = 0;
        push_dump();
        start[1] = 1'b1;
        step(1);
        start[1] = 1'b0;
        chk("m_restart_done", 64'(done[1]), 64'd0);
        chk("m_restart_busy", 64'(busy[1]), 64'd1);
        run_until_done(1, 400);
        chk("m_beats2", 64'(nb), 64'd64);
        chk("m_sb_empty2", 64'(sbq.size()), 64'd0);

        // Same-edge start and auto trigger, then counter saturation
        rel(2);
        repeat (4) step(2);
        push_dump();
        start[2] = 1'b1;
        step(2);
        start[2] = 1'b0;
        chk("s_busy", 64'(busy[2]), 64'd1);
        run_until_done(2, 400);
        chk("s_first_valid_edge", 64'(first_v), 64'd6);
        chk("s_beats", 64'(nb), 64'd64);
        repeat (40) step(2);
        chk("s_no_refire", {done[2], busy[2], valid[2]}, 64'b100);
        chk("s_sb_empty", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
